fir_mac_scheduler: RTL and testbench

//  Time-multiplexes one pipelined 24s x 13u multiplier (37-bit signed product, MUL_LAT cycles) across NTAPS FIR taps.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_mac_scheduler_if.sv | 36 +++
 rtl/fir_delay_line.sv | 39 +++
 rtl/fir_mac_scheduler.sv | 149 ++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared widths, FSM state type and accumulator sizing for the time-multiplexed FIR MAC scheduler.
package fir_pkg;

    localparam int X_W = 24;
    localparam int C_W = 13;
    localparam int P_W = 37;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    // Headroom for summing ntaps full-scale products without overflow.
    function automatic int acc_w(input int ntaps);
        return P_W + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample, output, coefficient-config and external-multiplier signals of fir_mac_scheduler.
interface fir_mac_scheduler_if #(
    parameter int NTAPS = 8,
    parameter int OUT_W = 24
);
    localparam int AW = $clog2(NTAPS);

    logic                             x_valid;
    logic                             x_ready;
    logic signed [fir_pkg::X_W-1:0]   x_data;

    logic                             y_valid;
    logic                             y_ready;
    logic        [OUT_W-1:0]          y_data;

    logic                             cfg_we;
    logic        [AW-1:0]             cfg_addr;
    logic        [fir_pkg::C_W-1:0]   cfg_data;
    logic                             cfg_busy;

    logic                             mul_ce;
    logic signed [fir_pkg::X_W-1:0]   mul_a;
    logic        [fir_pkg::C_W-1:0]   mul_b;
    logic signed [fir_pkg::P_W-1:0]   mul_p;

    modport slave (
        input  x_valid, x_data, y_ready, cfg_we, cfg_addr, cfg_data, mul_p,
        output x_ready, y_valid, y_data, cfg_busy, mul_ce, mul_a, mul_b
    );

    modport master (
        output x_valid, x_data, y_ready, cfg_we, cfg_addr, cfg_data, mul_p,
        input  x_ready, y_valid, y_data, cfg_busy, mul_ce, mul_a, mul_b
    );

endinterface

// File: rtl/fir_delay_line.sv
// NTAPS-deep circular sample history: one write port at wp, one combinational read at (wp - k) mod NTAPS.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int  NTAPS = 8,
    localparam int AW    = $clog2(NTAPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         wp,
    input  logic signed [X_W-1:0] wdata,
    input  logic [AW-1:0]         k,
    output logic signed [X_W-1:0] rdata
);

    logic signed [X_W-1:0] dl [NTAPS];
    logic [AW-1:0]         rd_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                dl[i] <= '0;
            end
        end else if (we) begin
            dl[wp] <= wdata;
        end
    end

    // Borrow case adds NTAPS back so non-power-of-two depths wrap correctly.
    always_comb begin
        rd_idx = wp - k;
        if (wp < k) begin
            rd_idx = wp - k + AW'(NTAPS);
        end
        rdata = dl[rd_idx];
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one external pipelined multiplier shared across NTAPS taps.
// Define FIR_SAT_EN to clip the output to OUT_W; otherwise the output wraps.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int NTAPS      = 8,
    parameter int MUL_LAT    = 3,
    parameter int FRAC_SHIFT = 12,
    parameter int OUT_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    fir_mac_scheduler_if.slave  bus
);

    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = acc_w(NTAPS);
    localparam logic [MUL_LAT-1:0] LAST_ONLY = MUL_LAT'(1) << (MUL_LAT - 1);

    state_t                  state;
    logic [AW-1:0]           wp;
    logic [AW-1:0]           tap;
    logic [MUL_LAT-1:0]      vld_sr;
    logic signed [ACC_W-1:0] acc;
    logic [C_W-1:0]          coef [NTAPS];

    logic                    accept;
    logic                    issuing;
    logic                    last_tap;
    logic                    prod_vld;
    logic                    drain_done;
    logic signed [X_W-1:0]   dl_rdata;
    logic signed [ACC_W-1:0] prod_ext;
    logic [OUT_W-1:0]        y_next;

    fir_delay_line #(
        .NTAPS (NTAPS)
    ) u_delay_line (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .wp    (wp),
        .wdata (bus.x_data),
        .k     (tap),
        .rdata (dl_rdata)
    );

    assign accept     = (state == IDLE) && bus.x_valid;
    assign issuing    = (state == ISSUE);
    assign last_tap   = (tap == AW'(NTAPS - 1));
    assign prod_vld   = vld_sr[MUL_LAT-1];
    // Only the final tag remains in flight: this edge accumulates the last product.
    assign drain_done = (vld_sr == LAST_ONLY);
    assign prod_ext   = {{(ACC_W-P_W){bus.mul_p[P_W-1]}}, bus.mul_p};

    assign bus.mul_a  = issuing ? dl_rdata  : '0;
    assign bus.mul_b  = issuing ? coef[tap] : '0;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [ACC_W-1:0] r;

    always_comb begin
        r = acc >>> FRAC_SHIFT;
        if (r > SAT_MAX) begin
            y_next = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (r < SAT_MIN) begin
            y_next = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            y_next = r[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        y_next = OUT_W'(acc >>> FRAC_SHIFT);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (state == IDLE && bus.cfg_we && 32'(bus.cfg_addr) < NTAPS) begin
            coef[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wp           <= '0;
            tap          <= '0;
            vld_sr       <= '0;
            acc          <= '0;
            bus.x_ready  <= 1'b1;
            bus.cfg_busy <= 1'b0;
            bus.mul_ce   <= 1'b0;
            bus.y_valid  <= 1'b0;
            bus.y_data   <= '0;
        end else begin
            // Tag each issued tap; the tag surfaces alongside its product.
            vld_sr <= MUL_LAT'({vld_sr, issuing});
            if (prod_vld) begin
                acc <= acc + prod_ext;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        acc          <= '0;
                        tap          <= '0;
                        state        <= ISSUE;
                        bus.x_ready  <= 1'b0;
                        bus.cfg_busy <= 1'b1;
                        bus.mul_ce   <= 1'b1;
                    end
                end
                ISSUE: begin
                    tap <= tap + AW'(1);
                    if (last_tap) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (!bus.y_valid) begin
                        bus.y_valid <= 1'b1;
                        bus.y_data  <= y_next;
                    end else if (bus.y_ready) begin
                        bus.y_valid  <= 1'b0;
                        wp           <= (wp == AW'(NTAPS - 1)) ? '0 : wp + AW'(1);
                        state        <= IDLE;
                        bus.x_ready  <= 1'b1;
                        bus.cfg_busy <= 1'b0;
                        bus.mul_ce   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler with a behavioural 3-cycle multiplier and FIR reference model.
`timescale 1ns/1ps
module tb_fir_mac_scheduler;
    import fir_pkg::*;

    localparam int NT  = 8;
    localparam int LAT = 3;
    localparam int FS  = 12;
    localparam int OW  = 24;
    localparam int AW  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fir_mac_scheduler_if #(.NTAPS(NT), .OUT_W(OW)) bus ();

    fir_mac_scheduler #(
        .NTAPS(NT), .MUL_LAT(LAT), .FRAC_SHIFT(FS), .OUT_W(OW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Multiplier owned by the parent: LAT-stage pipeline gated by mul_ce.
    logic signed [P_W-1:0] mpipe [LAT];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
        end else if (bus.mul_ce) begin
            mpipe[0] <= P_W'($signed(bus.mul_a) * $signed({1'b0, bus.mul_b}));
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign bus.mul_p = mpipe[LAT-1];

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { longint y; longint cyc; } exp_t;
    exp_t sbq[$];
    exp_t me;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   rand_rdy = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: explicit history and coefficient arrays, plain arithmetic.
    int hist [NT];
    int mcoef [NT];
    int mwp;

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            hist[i] = 0;
            mcoef[i] = 0;
        end
        mwp = 0;
    endtask

    function automatic longint model_y();
        longint s = 0;
        longint lim = longint'(1) <<< (OW - 1);
        for (int k = 0; k < NT; k++)
            s += longint'(hist[(mwp - k + NT) % NT]) * longint'(mcoef[k]);
        s = s >>> FS;
`ifdef FIR_SAT_EN
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
`else
        s = longint'($signed(s[OW-1:0]));
        if (lim == 0) s = 0;
`endif
        return s;
    endfunction

    // Monitor: pops one expectation per presented output, then checks it is held.
    bit     pending = 0;
    longint held;
    always @(negedge clk) begin
        if (!reset) begin
            pending = 0;
        end else if (bus.y_valid) begin
            if (!pending) begin
                if (sbq.size() == 0) begin
                    check("unexpected_y_valid", 1, 0);
                end else begin
                    me = sbq.pop_front();
                    check("y_data", longint'($signed(bus.y_data)), me.y);
                    check("y_latency", cyc, me.cyc + NT + LAT + 1);
                end
                pending = 1;
                held = longint'($signed(bus.y_data));
            end else begin
                check("y_stable", longint'($signed(bus.y_data)), held);
            end
            if (bus.y_ready) pending = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.y_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!bus.x_ready && n < 500) begin
            tick();
            n++;
        end
        if (!bus.x_ready) check("x_ready_timeout", 0, 1);
    endtask

    task automatic cfg_write(input int addr, input int data);
        wait_idle();
        bus.cfg_we = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = C_W'(data);
        if (addr < NT) mcoef[addr] = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic send(input int x);
        exp_t ent;
        wait_idle();
        if (!bus.x_ready) return;
        bus.x_valid = 1'b1;
        bus.x_data = X_W'(x);
        if (bus.cfg_we && int'(bus.cfg_addr) < NT) mcoef[bus.cfg_addr] = int'(bus.cfg_data);
        hist[mwp] = x;
        ent.y = model_y();
        ent.cyc = cyc + 1;
        sbq.push_back(ent);
        mwp = (mwp + 1) % NT;
        tick();
        bus.x_valid = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((sbq.size() != 0 || pending || bus.y_valid) && n < 1000) begin
            tick();
            n++;
        end
        check("drain_timeout", sbq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_ready"}, bus.x_ready, 1);
        check({tag, "_y_valid"}, bus.y_valid, 0);
        check({tag, "_y_data"}, bus.y_data, 0);
        check({tag, "_cfg_busy"}, bus.cfg_busy, 0);
        check({tag, "_mul_ce"}, bus.mul_ce, 0);
        check({tag, "_mul_a"}, bus.mul_a, 0);
        check({tag, "_mul_b"}, bus.mul_b, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        bus.x_valid = 0;
        bus.x_data = '0;
        bus.y_ready = 1;
        bus.cfg_we = 0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        model_reset();
        tick(); tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Impulse through a ramp of coefficients.
        for (int k = 0; k < NT; k++) cfg_write(k, k + 1);
        send(4096);
        for (int i = 0; i < NT - 1; i++) send(0);
        wait_drain();

        // Sign handling with a single unit tap.
        for (int k = 0; k < NT; k++) cfg_write(k, (k == 0) ? 1 : 0);
        send(-4096);
        send(8388607);
        wait_drain();

        // Full-scale accumulation.
        for (int k = 0; k < NT; k++) cfg_write(k, 8191);
        for (int i = 0; i < NT; i++) send(8388607);
        wait_drain();

        // Output backpressure.
        bus.y_ready = 0;
        send(123456);
        n = 0;
        while (!bus.y_valid && n < 100) begin tick(); n++; end
        check("bp_y_valid_seen", bus.y_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_x_ready", bus.x_ready, 0);
            check("bp_y_valid_held", bus.y_valid, 1);
        end
        bus.y_ready = 1;
        tick();
        check("bp_y_valid_drop", bus.y_valid, 0);
        check("bp_x_ready_back", bus.x_ready, 1);
        check("bp_cfg_busy_clear", bus.cfg_busy, 0);
        wait_drain();

        // Coefficient write while busy is dropped; write on the accept edge is honoured.
        for (int k = 0; k < NT; k++) cfg_write(k, k + 1);
        send(4096);
        tick();
        bus.cfg_we = 1;
        bus.cfg_addr = AW'(0);
        bus.cfg_data = C_W'(100);
        check("busy_cfg_busy", bus.cfg_busy, 1);
        tick();
        bus.cfg_we = 0;
        for (int i = 0; i < NT - 1; i++) send(0);
        wait_drain();
        wait_idle();
        bus.cfg_we = 1;
        bus.cfg_addr = AW'(2);
        bus.cfg_data = C_W'(4000);
        send(4096);
        wait_drain();

        // Asynchronous reset while issuing tap 3.
        send(4096);
        tick(); tick(); tick();
        check("mid_mul_ce", bus.mul_ce, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(sbq.pop_back());
        tick(); tick();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) tick();
        send(4096);
        wait_drain();

        // Randomized traffic with random output acceptance.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 8191)));
            if ($urandom_range(0, 7) == 0) begin
                wait_idle();
                bus.cfg_we = 1;
                bus.cfg_addr = AW'($urandom_range(0, NT - 1));
                bus.cfg_data = C_W'($urandom_range(0, 8191));
            end
            send(int'($urandom_range(0, 16777215)) - 8388608);
        end
        rand_rdy = 0;
        bus.y_ready = 1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
